// File: rtl/cam_capture_pkr_pkg.sv
// Shared types and default geometry for the camera capture front-end.
package cam_pkg;

    typedef enum logic [1:0] {
        SYNC,
        IDLE,
        CAPTURE
    } cap_state_t;

    // Default sensor geometry: 640x480 at 2 bytes per pixel
    localparam int H_PIXELS        = 640;
    localparam int V_LINES         = 480;
    localparam int BYTES_PER_PIXEL = 2;

    localparam int DEF_BUS_W       = 128;
    localparam int DEF_ROW_BYTES   = H_PIXELS * BYTES_PER_PIXEL;
    localparam int DEF_FRAME_ROWS  = V_LINES;
    localparam int DEF_EXP_ROW     = V_LINES;
    localparam int DEF_NUM_EXP     = 3;
    localparam int DEF_FRAME_SLOTS = 6;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cam_capture_pkr_if.sv
// DVP byte stream in, packed beat out towards the DDR write FIFO.
interface cam_capture_pkr_if
    import cam_pkg::*;
#(
    parameter int BUS_W = DEF_BUS_W
) ();

    logic [7:0]       data;
    logic             href;
    logic             vsync;
    logic             data_ready;
    logic [BUS_W-1:0] p_data;
    logic             data_valid;

    // Camera/FIFO side
    modport master (
        output data, href, vsync, data_ready,
        input  p_data, data_valid
    );

    // Capture block side
    modport slave (
        input  data, href, vsync, data_ready,
        output p_data, data_valid
    );

endinterface

// File: rtl/cam_capture_pkr_pix_packer.sv
// Byte-to-beat packer: first byte of a beat lands in the LSBs.
module pix_packer
    import cam_pkg::*;
#(
    parameter int BUS_W = DEF_BUS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic             flush,
    input  logic [7:0]       data,
    output logic [BUS_W-1:0] beat,
    output logic             valid
);

    localparam int BYTES = BUS_W / 8;
    localparam int CNT_W = $clog2(BYTES);

    logic [CNT_W-1:0] cnt;
    logic [BUS_W-1:0] shreg;

    // Shift bytes in from the top; a full beat is copied out with a one-cycle strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            shreg <= '0;
            beat  <= '0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clr) begin
                cnt   <= '0;
                shreg <= '0;
                beat  <= '0;
            end else if (flush) begin
                // Partial beat is dropped; stale shreg bytes are overwritten by the next full beat
                cnt <= '0;
            end else if (load) begin
                shreg <= {data, shreg[BUS_W-1:8]};
                if (cnt == CNT_W'(BYTES - 1)) begin
                    cnt   <= '0;
                    beat  <= {data, shreg[BUS_W-1:8]};
                    valid <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cam_capture_pkr.sv
// Camera capture front-end: frame sync FSM, geometry checks, slot/exposure tracking.
module cam_capture_pkr
    import cam_pkg::*;
#(
    parameter int BUS_W       = DEF_BUS_W,
    parameter int ROW_BYTES   = DEF_ROW_BYTES,
    parameter int FRAME_ROWS  = DEF_FRAME_ROWS,
    parameter int EXP_ROW     = DEF_EXP_ROW,
    parameter int NUM_EXP     = DEF_NUM_EXP,
    parameter int FRAME_SLOTS = DEF_FRAME_SLOTS,
    localparam int EXP_W      = clog2_min1(NUM_EXP),
    localparam int SLOT_W     = $clog2(FRAME_SLOTS)
) (
    input  logic              p_clk,
    input  logic              rst_n,
    cam_capture_pkr_if.slave  bus,
    input  logic              take_pic,
    input  logic              hdr_en,
    output logic              frame_done,
    output logic              frame_err,
    output logic              overflow,
    output logic              change_exp,
    output logic [EXP_W-1:0]  exp_idx,
    output logic [SLOT_W-1:0] frame_slot
);

    localparam int BYTES = BUS_W / 8;
    // Counters are one value wider than the legal maximum so saturation always reads as an error
    localparam int RB_W  = $clog2(ROW_BYTES + 2);
    localparam int ROW_W = $clog2(FRAME_ROWS + 2);

    if (BUS_W % 8 != 0 || BUS_W < 16) begin : g_bad_bus_w
        $error("BUS_W must be a multiple of 8 and at least 16");
    end
    if (ROW_BYTES % BYTES != 0) begin : g_bad_row_bytes
        $error("ROW_BYTES must be a multiple of BUS_W/8");
    end
    if (EXP_ROW < 1 || EXP_ROW > FRAME_ROWS) begin : g_bad_exp_row
        $error("EXP_ROW must lie in 1..FRAME_ROWS");
    end
    if (NUM_EXP < 1 || FRAME_SLOTS < 2) begin : g_bad_counts
        $error("NUM_EXP must be >= 1 and FRAME_SLOTS >= 2");
    end

    cap_state_t       state;
    logic             href_q;
    logic [RB_W-1:0]  row_bytes;
    logic [ROW_W-1:0] rows;
    logic             row_bad;
    logic             exp_fired;
    logic             load;

    // A byte is taken only while a row is active inside a captured frame
    always_comb load = (state == CAPTURE) && bus.href;

    pix_packer #(
        .BUS_W (BUS_W)
    ) u_packer (
        .clk   (p_clk),
        .rst_n (rst_n),
        .clr   (take_pic),
        .load  (load),
        .flush (!load),
        .data  (bus.data),
        .beat  (bus.p_data),
        .valid (bus.data_valid)
    );

    // Frame FSM with row/geometry bookkeeping, slot and exposure counters, sticky overflow
    always_ff @(posedge p_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SYNC;
            href_q     <= 1'b0;
            row_bytes  <= '0;
            rows       <= '0;
            row_bad    <= 1'b0;
            exp_fired  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
            change_exp <= 1'b0;
            exp_idx    <= '0;
            frame_slot <= '0;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            change_exp <= 1'b0;
            href_q     <= bus.href;
            if (take_pic) begin
                state     <= SYNC;
                row_bytes <= '0;
                rows      <= '0;
                row_bad   <= 1'b0;
                exp_fired <= 1'b0;
                overflow  <= 1'b0;
                exp_idx   <= '0;
            end else begin
                if (bus.data_valid && !bus.data_ready) begin
                    overflow <= 1'b1;
                end
                case (state)
                    SYNC: begin
                        if (bus.vsync) state <= IDLE;
                    end
                    IDLE: begin
                        row_bytes <= '0;
                        rows      <= '0;
                        row_bad   <= 1'b0;
                        exp_fired <= 1'b0;
                        if (!bus.vsync) state <= CAPTURE;
                    end
                    CAPTURE: begin
                        if (bus.vsync) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                            frame_err  <= row_bad || (rows != ROW_W'(FRAME_ROWS));
                            frame_slot <= (frame_slot == SLOT_W'(FRAME_SLOTS - 1)) ? '0 : frame_slot + 1'b1;
                            if (hdr_en) begin
                                exp_idx <= (exp_idx == EXP_W'(NUM_EXP - 1)) ? '0 : exp_idx + 1'b1;
                            end
                        end
                        if (bus.href) begin
                            if (row_bytes != '1) row_bytes <= row_bytes + 1'b1;
                        end else if (href_q) begin
                            if (rows != '1) rows <= rows + 1'b1;
                            if (row_bytes != RB_W'(ROW_BYTES)) row_bad <= 1'b1;
                            row_bytes <= '0;
                        end
                        if (hdr_en && !exp_fired && (rows == ROW_W'(EXP_ROW))) begin
                            change_exp <= 1'b1;
                            exp_fired  <= 1'b1;
                        end
                    end
                    default: state <= SYNC;
                endcase
                if (!hdr_en) exp_idx <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_pkr.sv
// Randomised frame-level bench for cam_capture_pkr with a transaction reference model.
module tb_cam_capture_pkr;

    localparam int BUS_W       = 32;
    localparam int ROW_BYTES   = 8;
    localparam int FRAME_ROWS  = 4;
    localparam int EXP_ROW     = 3;
    localparam int NUM_EXP     = 3;
    localparam int FRAME_SLOTS = 6;
    localparam int BYTES       = BUS_W / 8;

    typedef struct {
        logic [BUS_W-1:0] data;
        int               at;
    } beat_t;

    typedef struct {
        int   at;
        logic err;
        int   slot;
        int   exp_v;
        logic ovf;
    } frm_t;

    logic       p_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       take_pic = 1'b0;
    logic       hdr_en = 1'b0;
    logic       frame_done, frame_err, overflow, change_exp;
    logic [1:0] exp_idx;
    logic [2:0] frame_slot;

    cam_capture_pkr_if #(.BUS_W(BUS_W)) bus ();

    cam_capture_pkr #(
        .BUS_W       (BUS_W),
        .ROW_BYTES   (ROW_BYTES),
        .FRAME_ROWS  (FRAME_ROWS),
        .EXP_ROW     (EXP_ROW),
        .NUM_EXP     (NUM_EXP),
        .FRAME_SLOTS (FRAME_SLOTS)
    ) dut (
        .p_clk      (p_clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .take_pic   (take_pic),
        .hdr_en     (hdr_en),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .change_exp (change_exp),
        .exp_idx    (exp_idx),
        .frame_slot (frame_slot)
    );

    always #5 p_clk = ~p_clk;

    int cyc = 0;
    always @(posedge p_clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_chk++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // Reference model state
    beat_t      beat_q[$];
    frm_t       frame_q[$];
    int         chg_q[$];
    int         m_slot = 0;
    int         m_exp = 0;
    logic       m_ovf = 1'b0;
    int         last_beat_at = -10;
    logic       busy = 1'b0;
    logic       rnd_ready = 1'b0;
    logic       seq_mode = 1'b0;
    logic [7:0] seq_byte = 8'h00;
    int         row_len[8];

    // One pixel-clock cycle of stimulus; overflow expectation follows the beat handshake
    task automatic step(input logic [7:0] d, input logic h, input logic v, input logic tp);
        int e;
        e = cyc + 1;
        bus.data  = d;
        bus.href  = h;
        bus.vsync = v;
        take_pic  = tp;
        bus.data_ready = busy ? 1'b0 : (rnd_ready ? ($urandom_range(0, 7) != 0) : 1'b1);
        if (tp) m_ovf = 1'b0;
        else if (e == last_beat_at + 1 && !bus.data_ready) m_ovf = 1'b1;
        @(posedge p_clk);
        #1;
    endtask

    task automatic send_row(input int n, input logic live);
        logic [BUS_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            int e;
            d = seq_mode ? seq_byte : 8'($urandom);
            seq_byte = seq_byte + 8'd1;
            e = cyc + 1;
            acc[8*(i%BYTES) +: 8] = d;
            step(d, 1'b1, 1'b0, 1'b0);
            if (live && (i % BYTES == BYTES - 1)) begin
                beat_q.push_back('{acc, e});
                last_beat_at = e;
            end
        end
    endtask

    // One vsync frame: idle, rows with gaps, optional take_pic/reset/busy disturbances
    task automatic send_frame(input int nrows, input logic hdr, input int tp_row,
                              input int rst_row, input logic tp_end, input int busy_row);
        logic live;
        logic bad;
        int   rows;
        int   g;
        int   v;
        live = 1'b1;
        bad  = 1'b0;
        rows = 0;
        hdr_en = hdr;
        if (!hdr) m_exp = 0;
        repeat (3) step(8'h00, 1'b0, 1'b1, 1'b0);
        repeat (2) step(8'h00, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < nrows; r++) begin
            busy = (r == busy_row);
            send_row(row_len[r], live);
            g = cyc + 1;
            step(8'h00, 1'b0, 1'b0, 1'b0);
            busy = 1'b0;
            if (live) begin
                rows++;
                if (row_len[r] != ROW_BYTES) bad = 1'b1;
                if (hdr && rows == EXP_ROW) chg_q.push_back(g + 1);
            end
            step(8'h00, 1'b0, 1'b0, 1'b0);
            if (r == tp_row) begin
                step(8'h00, 1'b0, 1'b0, 1'b1);
                live  = 1'b0;
                m_exp = 0;
            end else if (r == rst_row) begin
                rst_n = 1'b0;
                step(8'h00, 1'b0, 1'b0, 1'b0);
                step(8'h00, 1'b0, 1'b0, 1'b0);
                rst_n  = 1'b1;
                live   = 1'b0;
                m_slot = 0;
                m_exp  = 0;
                m_ovf  = 1'b0;
            end
            repeat ($urandom_range(0, 2)) step(8'h00, 1'b0, 1'b0, 1'b0);
        end
        if (tp_end) begin
            step(8'h00, 1'b0, 1'b1, 1'b1);
            m_exp = 0;
        end else if (live) begin
            v = cyc + 1;
            step(8'h00, 1'b0, 1'b1, 1'b0);
            m_slot = (m_slot + 1) % FRAME_SLOTS;
            if (hdr) m_exp = (m_exp + 1) % NUM_EXP;
            frame_q.push_back('{v, bad || (rows != FRAME_ROWS), m_slot, m_exp, m_ovf});
        end else begin
            step(8'h00, 1'b0, 1'b1, 1'b0);
        end
        step(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic full_rows();
        for (int i = 0; i < 8; i++) row_len[i] = ROW_BYTES;
    endtask

    // Output monitor: every strobe must match the head of its expectation queue
    always @(negedge p_clk) begin
        if (rst_n) begin
            while (beat_q.size() > 0 && beat_q[0].at < cyc) begin
                chk("beat_late", 128'(cyc), 128'(beat_q[0].at));
                beat_q.delete(0);
            end
            while (frame_q.size() > 0 && frame_q[0].at < cyc) begin
                chk("frame_done_late", 128'(cyc), 128'(frame_q[0].at));
                frame_q.delete(0);
            end
            while (chg_q.size() > 0 && chg_q[0] < cyc) begin
                chk("change_exp_late", 128'(cyc), 128'(chg_q[0]));
                chg_q.delete(0);
            end
            if (bus.data_valid) begin
                if (beat_q.size() == 0) chk("data_valid_spurious", bus.data_valid, 1'b0);
                else begin
                    chk("beat_data", bus.p_data, beat_q[0].data);
                    chk("beat_cycle", 128'(cyc), 128'(beat_q[0].at));
                    beat_q.delete(0);
                end
            end
            if (frame_done) begin
                if (frame_q.size() == 0) chk("frame_done_spurious", frame_done, 1'b0);
                else begin
                    chk("frame_cycle", 128'(cyc), 128'(frame_q[0].at));
                    chk("frame_err", frame_err, frame_q[0].err);
                    chk("frame_slot", frame_slot, 128'(frame_q[0].slot));
                    chk("exp_idx", exp_idx, 128'(frame_q[0].exp_v));
                    chk("overflow", overflow, frame_q[0].ovf);
                    frame_q.delete(0);
                end
            end
            if (frame_err && !frame_done) chk("frame_err_alone", frame_err, frame_done);
            if (change_exp) begin
                if (chg_q.size() == 0) chk("change_exp_spurious", change_exp, 1'b0);
                else begin
                    chk("change_exp_cycle", 128'(cyc), 128'(chg_q[0]));
                    chg_q.delete(0);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nr;
        bus.data = 8'h00;
        bus.href = 1'b0;
        bus.vsync = 1'b1;
        bus.data_ready = 1'b1;
        repeat (3) @(posedge p_clk);
        #1;
        chk("rst_p_data", bus.p_data, '0);
        chk("rst_data_valid", bus.data_valid, 1'b0);
        chk("rst_frame_done", frame_done, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_change_exp", change_exp, 1'b0);
        chk("rst_exp_idx", exp_idx, '0);
        chk("rst_frame_slot", frame_slot, '0);
        rst_n = 1'b1;

        // Nominal frame with incrementing bytes
        full_rows();
        seq_mode = 1'b1;
        seq_byte = 8'h00;
        send_frame(4, 1'b1, -1, -1, 1'b0, -1);
        seq_mode = 1'b0;
        chk("nominal_slot", frame_slot, 128'(m_slot));

        // HDR cycling and slot wrap
        repeat (7) send_frame(4, 1'b1, -1, -1, 1'b0, -1);
        chk("hdr_slot_after_wrap", frame_slot, 128'(m_slot));

        // Short row, then too many rows
        row_len[1] = 6;
        send_frame(4, 1'b1, -1, -1, 1'b0, -1);
        full_rows();
        send_frame(5, 1'b1, -1, -1, 1'b0, -1);

        // Downstream busy during the third beat, sticky across the next frame
        send_frame(4, 1'b1, -1, -1, 1'b0, 1);
        send_frame(4, 1'b1, -1, -1, 1'b0, -1);
        chk("overflow_sticky", overflow, m_ovf);
        step(8'h00, 1'b0, 1'b1, 1'b1);
        m_exp = 0;
        chk("overflow_cleared", overflow, m_ovf);
        chk("take_pic_exp_cleared", exp_idx, 128'(m_exp));

        // Reset mid-frame, then a clean frame
        send_frame(4, 1'b1, -1, 1, 1'b0, -1);
        chk("slot_after_reset", frame_slot, 128'(m_slot));
        send_frame(4, 1'b1, -1, -1, 1'b0, -1);

        // take_pic mid-frame abandons the frame
        send_frame(4, 1'b1, 1, -1, 1'b0, -1);
        chk("slot_after_take_pic", frame_slot, 128'(m_slot));
        send_frame(4, 1'b1, -1, -1, 1'b0, -1);

        // HDR disabled
        repeat (3) begin
            send_frame(4, 1'b0, -1, -1, 1'b0, -1);
            chk("hdr_off_exp_idx", exp_idx, 128'(m_exp));
        end

        // take_pic coincident with the vsync rise
        send_frame(4, 1'b1, -1, -1, 1'b1, -1);
        chk("tp_vsync_slot", frame_slot, 128'(m_slot));
        send_frame(4, 1'b1, -1, -1, 1'b0, -1);

        // Randomised frames
        rnd_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            nr = int'($urandom_range(3, 5));
            for (int r = 0; r < 8; r++)
                row_len[r] = ($urandom_range(0, 9) < 7) ? ROW_BYTES : int'($urandom_range(1, 20));
            send_frame(nr, 1'($urandom_range(0, 1)),
                       ($urandom_range(0, 7) == 0) ? 1 : -1, -1,
                       1'($urandom_range(0, 9) == 0),
                       ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, nr - 1)) : -1);
        end
        rnd_ready = 1'b0;

        repeat (5) step(8'h00, 1'b0, 1'b1, 1'b0);
        chk("beats_outstanding", 128'(beat_q.size()), 128'(0));
        chk("frames_outstanding", 128'(frame_q.size()), 128'(0));
        chk("change_exp_outstanding", 128'(chg_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
